// File: rtl/riscv_pkg.sv
// Shared RISC-V types used by the FP writeback path.
package riscv_pkg;

    // IEEE exception flags in fflags bit order: NV is bit 4, NX is bit 0.
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fp_flags_t;

endpackage

// File: rtl/fpu_result_writeback_if.sv
// FP register file writeback channel: valid/ready handshake with payload.
interface fpu_result_writeback_if #(
    parameter int FP_WIDTH_D = 64
) ();

    logic                   valid;
    logic                   ready;
    logic [4:0]             dest;
    logic [FP_WIDTH_D-1:0]  data;
    riscv_pkg::fp_flags_t   flags;

    // Writeback producer (the arbiter).
    modport master (
        output valid,
        output dest,
        output data,
        output flags,
        input  ready
    );

    // Writeback consumer (the FP register file write port).
    modport slave (
        input  valid,
        input  dest,
        input  data,
        input  flags,
        output ready
    );

endinterface

// File: rtl/fpu_result_writeback.sv
// Collects results from the non-stallable FPU units into small per-source
// queues and drains them round-robin onto the single FP regfile write port,
// accruing exception flags and flagging any result lost to a full queue.
module fpu_result_writeback #(
    parameter int FP_WIDTH_D = 64,
    parameter int NUM_SRC    = 3,
    parameter int DEPTH      = 2
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [NUM_SRC-1:0]                   i_src_valid,
    input  logic [NUM_SRC-1:0][FP_WIDTH_D-1:0]   i_src_result,
    input  riscv_pkg::fp_flags_t [NUM_SRC-1:0]   i_src_flags,
    input  logic [NUM_SRC-1:0][4:0]              i_src_dest,
    fpu_result_writeback_if.master               wb,
    output logic [NUM_SRC-1:0]                   o_src_full,
    input  logic                                 i_fflags_clear,
    output riscv_pkg::fp_flags_t                 o_fflags,
    output logic                                 o_overflow,
    output logic                                 o_idle
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Queue storage; contents are never reset, only pointers and counts.
    logic [FP_WIDTH_D-1:0]  q_data  [NUM_SRC][DEPTH];
    riscv_pkg::fp_flags_t   q_flags [NUM_SRC][DEPTH];
    logic [4:0]             q_dest  [NUM_SRC][DEPTH];

    logic [PTR_W-1:0]       rd_ptr  [NUM_SRC];
    logic [PTR_W-1:0]       wr_ptr  [NUM_SRC];
    logic [CNT_W-1:0]       count   [NUM_SRC];

    logic [IDX_W-1:0]       rr_ptr;
    riscv_pkg::fp_flags_t   fflags_q;
    riscv_pkg::fp_flags_t   fflags_next;
    logic                   overflow_q;

    logic [NUM_SRC-1:0]     nonempty;
    logic [NUM_SRC-1:0]     full;
    logic [NUM_SRC-1:0]     push;
    logic [NUM_SRC-1:0]     pop;
    logic [NUM_SRC-1:0]     accept;
    logic [NUM_SRC-1:0]     drop;

    logic                   grant_vld;
    logic [IDX_W-1:0]       grant_idx;
    logic [IDX_W-1:0]       rr_next;
    logic                   handshake;

    logic [FP_WIDTH_D-1:0]  head_data;
    riscv_pkg::fp_flags_t   head_flags;
    logic [4:0]             head_dest;

    // Per-queue occupancy and push/pop decisions; a push into a full queue
    // still lands when the same queue is popped on that edge.
    always_comb begin
        nonempty = '0;
        full     = '0;
        push     = '0;
        pop      = '0;
        accept   = '0;
        drop     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            nonempty[i] = (count[i] != '0);
            full[i]     = (count[i] == CNT_W'(DEPTH));
            push[i]     = i_src_valid[i] & ~i_rst;
            pop[i]      = handshake & (grant_idx == IDX_W'(i));
            accept[i]   = push[i] & (~full[i] | pop[i]);
            drop[i]     = push[i] & full[i] & ~pop[i];
        end
    end

    // Round-robin search: first non-empty queue at or after rr_ptr, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!grant_vld && nonempty[(int'(rr_ptr) + k) % NUM_SRC]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'((int'(rr_ptr) + k) % NUM_SRC);
            end
        end
    end

    // Select the head entry of the granted queue.
    always_comb begin
        head_data  = '0;
        head_flags = '0;
        head_dest  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                head_data  = q_data[i][rd_ptr[i]];
                head_flags = q_flags[i][rd_ptr[i]];
                head_dest  = q_dest[i][rd_ptr[i]];
            end
        end
    end

    // Outputs are forced quiet while reset is held so nothing escapes that cycle.
    assign wb.valid   = grant_vld & ~i_rst;
    assign wb.data    = wb.valid ? head_data  : '0;
    assign wb.flags   = wb.valid ? head_flags : '0;
    assign wb.dest    = wb.valid ? head_dest  : '0;
    assign handshake  = wb.valid & wb.ready;
    assign rr_next    = (grant_idx == IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx + IDX_W'(1);
    assign o_src_full = i_rst ? '0 : full;
    assign o_idle     = i_rst | ~(|nonempty);
    assign o_fflags   = i_rst ? '0 : fflags_q;
    assign o_overflow = overflow_q & ~i_rst;

    // Accrued flags: a CSR clear and a same-cycle writeback combine.
    always_comb begin
        fflags_next = i_fflags_clear ? '0 : fflags_q;
        if (handshake) begin
            fflags_next = riscv_pkg::fp_flags_t'(fflags_next | head_flags);
        end
    end

    // Write accepted results into their queue slot.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (accept[i]) begin
                q_data[i][wr_ptr[i]]  <= i_src_result[i];
                q_flags[i][wr_ptr[i]] <= i_src_flags[i];
                q_dest[i][wr_ptr[i]]  <= i_src_dest[i];
            end
        end
    end

    // Control state: pointers, counts, arbitration pointer, flags, overflow.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr     <= '0;
            fflags_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (accept[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                count[i] <= count[i] + CNT_W'(accept[i]) - CNT_W'(pop[i]);
            end
            if (|drop) begin
                overflow_q <= 1'b1;
            end
            if (handshake) begin
                rr_ptr <= rr_next;
            end
            fflags_q <= fflags_next;
        end
    end

endmodule

// File: tb/tb_fpu_result_writeback.sv
// Directed scenario bench for the FPU result writeback arbiter.
module tb_fpu_result_writeback;

    logic                            clk;
    logic                            rst;
    logic [2:0]                      src_valid;
    logic [2:0][63:0]                src_result;
    riscv_pkg::fp_flags_t [2:0]      src_flags;
    logic [2:0][4:0]                 src_dest;
    logic [2:0]                      src_full;
    logic                            fflags_clear;
    riscv_pkg::fp_flags_t            fflags;
    logic                            overflow;
    logic                            idle;

    int errors = 0;
    int checks = 0;

    fpu_result_writeback_if #(.FP_WIDTH_D(64)) wb_if ();

    fpu_result_writeback #(.FP_WIDTH_D(64), .NUM_SRC(3), .DEPTH(2)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_src_valid   (src_valid),
        .i_src_result  (src_result),
        .i_src_flags   (src_flags),
        .i_src_dest    (src_dest),
        .wb            (wb_if),
        .o_src_full    (src_full),
        .i_fflags_clear(fflags_clear),
        .o_fflags      (fflags),
        .o_overflow    (overflow),
        .o_idle        (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_src();
        src_valid  = '0;
        src_result = '0;
        src_flags  = '0;
        src_dest   = '0;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        clear_src();
        fflags_clear = 1'b0;
        wb_if.ready  = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        rst = 1'b1;
        src_valid = 3'b111;
        src_dest  = {5'd3, 5'd2, 5'd1};
        tick();
        @(negedge clk);
        checks++; if (wb_if.valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", wb_if.valid); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b want 1", idle); end
        checks++; if (src_full !== 3'b000) begin errors++; $display("FAIL rst_full: got %b want 000", src_full); end
        checks++; if (fflags !== 5'b00000) begin errors++; $display("FAIL rst_fflags: got %b want 00000", fflags); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b want 0", overflow); end
        tick();
        rst = 1'b0;
        clear_src();
        tick();
        @(negedge clk);
        checks++; if (wb_if.valid !== 1'b0) begin errors++; $display("FAIL rst_discard: got valid %b want 0", wb_if.valid); end
    endtask

    task automatic test_single();
        do_reset();
        wb_if.ready = 1'b1;
        tick();
        src_valid[0]  = 1'b1;
        src_dest[0]   = 5'd5;
        src_result[0] = 64'hFFFFFFFF3F800000;
        src_flags[0]  = 5'b00001;
        @(negedge clk);
        checks++; if (wb_if.valid !== 1'b0) begin errors++; $display("FAIL single_nobypass: got valid %b want 0", wb_if.valid); end
        tick();
        clear_src();
        @(negedge clk);
        checks++; if (wb_if.valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", wb_if.valid); end
        checks++; if (wb_if.dest !== 5'd5) begin errors++; $display("FAIL single_dest: got %0d want 5", wb_if.dest); end
        checks++; if (wb_if.data !== 64'hFFFFFFFF3F800000) begin errors++; $display("FAIL single_data: got %h want ffffffff3f800000", wb_if.data); end
        checks++; if (wb_if.flags !== 5'b00001) begin errors++; $display("FAIL single_flags: got %b want 00001", wb_if.flags); end
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_busy: got idle %b want 0", idle); end
        tick();
        @(negedge clk);
        checks++; if (wb_if.valid !== 1'b0) begin errors++; $display("FAIL single_done: got valid %b want 0", wb_if.valid); end
        checks++; if (wb_if.data !== 64'h0) begin errors++; $display("FAIL single_zero_data: got %h want 0", wb_if.data); end
        checks++; if (fflags !== 5'b00001) begin errors++; $display("FAIL single_fflags: got %b want 00001", fflags); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle: got %b want 1", idle); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        wb_if.ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            tick();
            src_valid = 3'b111;
            for (int s = 0; s < 3; s++) begin
                src_dest[s]   = 5'(b * 8 + s + 1);
                src_result[s] = 64'(64'h100 * (b + 1) + s);
            end
            tick();
            clear_src();
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                checks++; if (wb_if.valid !== 1'b1 || wb_if.dest !== 5'(b * 8 + k + 1))
                    begin errors++; $display("FAIL rr_order b%0d k%0d: got valid %b dest %0d want 1 dest %0d", b, k, wb_if.valid, wb_if.dest, b * 8 + k + 1); end
                checks++; if (wb_if.data !== 64'(64'h100 * (b + 1) + k))
                    begin errors++; $display("FAIL rr_data b%0d k%0d: got %h want %h", b, k, wb_if.data, 64'h100 * (b + 1) + k); end
                tick();
            end
        end
        @(negedge clk);
        checks++; if (wb_if.valid !== 1'b0) begin errors++; $display("FAIL rr_drained: got valid %b want 0", wb_if.valid); end
    endtask

    task automatic test_overflow();
        do_reset();
        wb_if.ready = 1'b0;
        tick();
        src_valid[1] = 1'b1; src_dest[1] = 5'd7; src_result[1] = 64'h7;
        tick();
        src_dest[1] = 5'd8; src_result[1] = 64'h8;
        @(negedge clk);
        checks++; if (src_full !== 3'b000) begin errors++; $display("FAIL ovf_notfull: got %b want 000", src_full); end
        tick();
        src_dest[1] = 5'd9; src_result[1] = 64'h9;
        @(negedge clk);
        checks++; if (src_full !== 3'b010) begin errors++; $display("FAIL ovf_full: got %b want 010", src_full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", overflow); end
        tick();
        clear_src();
        @(negedge clk);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
        checks++; if (wb_if.valid !== 1'b1 || wb_if.dest !== 5'd7) begin errors++; $display("FAIL ovf_head: got valid %b dest %0d want 1 dest 7", wb_if.valid, wb_if.dest); end
        tick();
        @(negedge clk);
        checks++; if (wb_if.dest !== 5'd7 || wb_if.data !== 64'h7) begin errors++; $display("FAIL ovf_stable: got dest %0d data %h want 7", wb_if.dest, wb_if.data); end
        tick();
        wb_if.ready = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (wb_if.valid !== 1'b1 || wb_if.dest !== 5'd8) begin errors++; $display("FAIL ovf_second: got valid %b dest %0d want 1 dest 8", wb_if.valid, wb_if.dest); end
        tick();
        @(negedge clk);
        checks++; if (wb_if.valid !== 1'b0) begin errors++; $display("FAIL ovf_only_two: got valid %b want 0", wb_if.valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        wb_if.ready = 1'b0;
        tick();
        src_valid[0] = 1'b1; src_dest[0] = 5'd1;
        tick();
        src_dest[0] = 5'd2;
        tick();
        wb_if.ready = 1'b1;
        src_dest[0] = 5'd3;
        @(negedge clk);
        checks++; if (src_full !== 3'b001 || wb_if.dest !== 5'd1) begin errors++; $display("FAIL fpp_pre: got full %b dest %0d want 001 dest 1", src_full, wb_if.dest); end
        tick();
        clear_src();
        @(negedge clk);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_no_overflow: got %b want 0", overflow); end
        checks++; if (src_full !== 3'b001) begin errors++; $display("FAIL fpp_count2: got full %b want 001", src_full); end
        checks++; if (wb_if.dest !== 5'd2) begin errors++; $display("FAIL fpp_second: got dest %0d want 2", wb_if.dest); end
        tick();
        @(negedge clk);
        checks++; if (wb_if.valid !== 1'b1 || wb_if.dest !== 5'd3 || src_full !== 3'b000)
            begin errors++; $display("FAIL fpp_third: got valid %b dest %0d full %b want 1 dest 3 full 000", wb_if.valid, wb_if.dest, src_full); end
        tick();
        @(negedge clk);
        checks++; if (wb_if.valid !== 1'b0) begin errors++; $display("FAIL fpp_drained: got valid %b want 0", wb_if.valid); end
    endtask

    task automatic test_fflags_clear();
        do_reset();
        wb_if.ready = 1'b1;
        tick();
        src_valid[2] = 1'b1; src_dest[2] = 5'd4; src_flags[2] = 5'b00001;
        tick();
        clear_src();
        tick();
        @(negedge clk);
        checks++; if (fflags !== 5'b00001) begin errors++; $display("FAIL ffl_accrue: got %b want 00001", fflags); end
        src_valid[1] = 1'b1; src_dest[1] = 5'd6; src_flags[1] = 5'b10000;
        tick();
        clear_src();
        fflags_clear = 1'b1;
        tick();
        fflags_clear = 1'b0;
        @(negedge clk);
        checks++; if (fflags !== 5'b10000) begin errors++; $display("FAIL ffl_clear_and_set: got %b want 10000", fflags); end
        tick();
        fflags_clear = 1'b1;
        tick();
        fflags_clear = 1'b0;
        @(negedge clk);
        checks++; if (fflags !== 5'b00000) begin errors++; $display("FAIL ffl_clear_only: got %b want 00000", fflags); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wb_if.ready = 1'b0;
        tick();
        src_valid[0] = 1'b1; src_dest[0] = 5'd1; src_flags[0] = 5'b00001;
        tick();
        src_dest[0] = 5'd2;
        tick();
        src_dest[0] = 5'd3;
        tick();
        clear_src();
        wb_if.ready = 1'b1;
        tick();
        wb_if.ready = 1'b0;
        src_valid[0] = 1'b1; src_dest[0] = 5'd4; src_flags[0] = 5'b00001;
        tick();
        clear_src();
        @(negedge clk);
        checks++; if (overflow !== 1'b1 || fflags !== 5'b00001 || src_full !== 3'b001 || wb_if.valid !== 1'b1)
            begin errors++; $display("FAIL mid_pre: got ovf %b ffl %b full %b valid %b want 1 00001 001 1", overflow, fflags, src_full, wb_if.valid); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (wb_if.valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", wb_if.valid); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mid_idle: got %b want 1", idle); end
        checks++; if (fflags !== 5'b00000) begin errors++; $display("FAIL mid_fflags: got %b want 00000", fflags); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow: got %b want 0", overflow); end
        checks++; if (src_full !== 3'b000) begin errors++; $display("FAIL mid_full: got %b want 000", src_full); end
        wb_if.ready = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (wb_if.valid !== 1'b0) begin errors++; $display("FAIL mid_no_emit: got valid %b want 0", wb_if.valid); end
    endtask

    initial begin
        rst          = 1'b1;
        fflags_clear = 1'b0;
        wb_if.ready  = 1'b0;
        clear_src();
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_fflags_clear();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpu_result_writeback.md
FPU_RESULT_WRITEBACK -- requirements
Module: fpu_result_writeback

Interface
REQ-001 Parameter FP_WIDTH_D, default 64: width of FP register write data; single results arrive already NaN-boxed.
REQ-002 Parameter NUM_SRC, default 3: number of FPU result sources (0 = adder unit, 1 = multiplier unit, 2 = divide/sqrt unit).
REQ-003 Parameter DEPTH, default 2: entries per source queue; SHALL be a power of two and at least 2.
REQ-004 i_clk  input  1  clock; all state updates on the rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 i_src_valid  input  NUM_SRC  one-cycle result strobe per source; sources cannot stall.
REQ-007 i_src_result  input  NUM_SRC x FP_WIDTH_D  result data per source.
REQ-008 i_src_flags  input  NUM_SRC x riscv_pkg::fp_flags_t  exception flags per source (NV, DZ, OF, UF, NX).
REQ-009 i_src_dest  input  NUM_SRC x 5  destination FP register per source.
REQ-010 i_wb_ready  input  1  FP regfile write port accepts this cycle.
REQ-011 o_wb_valid  output  1  a writeback is presented.
REQ-012 o_wb_dest / o_wb_data / o_wb_flags  output  5 / FP_WIDTH_D / fp_flags_t  writeback payload.
REQ-013 o_src_full  output  NUM_SRC  queue i holds DEPTH entries; issue logic SHALL NOT start source i while set.
REQ-014 i_fflags_clear  input  1  clears the accrued flags (CSR write to fflags).
REQ-015 o_fflags  output  fp_flags_t  accrued exception flags.
REQ-016 o_overflow  output  1  sticky error: a result was dropped.
REQ-017 o_idle  output  1  all queues empty.

Function
REQ-018 Each source SHALL have a DEPTH-entry FIFO of {result, flags, dest}; i_src_valid[i] pushes the entry into it on the same edge.
REQ-019 There is no bypass; a result pushed on cycle N SHALL appear on o_wb_* no earlier than cycle N+1.
REQ-020 Push to a full queue with no pop that cycle SHALL drop the entry and set o_overflow.
REQ-021 Push and pop in the same cycle on a full queue SHALL both succeed, and the count SHALL stay at DEPTH.
REQ-022 o_wb_valid SHALL be 1 iff any queue is non-empty.
REQ-023 Arbitration SHALL be round-robin: the grant goes to the first non-empty queue at or after rr_ptr, searching in increasing index order with wrap from NUM_SRC-1 to 0.
REQ-024 o_wb_* SHALL be driven combinationally from the head entry of the granted queue.
REQ-025 On handshake (o_wb_valid & i_wb_ready), the granted queue SHALL pop and rr_ptr SHALL become grant+1 modulo NUM_SRC; with no handshake, rr_ptr and the grant SHALL hold.
REQ-026 When o_wb_valid=1 and i_wb_ready=0, the payload SHALL remain stable until the handshake.
REQ-027 On handshake, o_fflags next value = (i_fflags_clear ? 0 : o_fflags) | o_wb_flags; with no handshake, it is (i_fflags_clear ? 0 : o_fflags).
REQ-028 Per-queue read and write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-029 When o_wb_valid=0, o_wb_data, o_wb_dest and o_wb_flags SHALL be 0.

Reset
REQ-030 While i_rst=1, all queues SHALL empty, rr_ptr=0, o_fflags=0, o_overflow=0, o_wb_valid=0, o_src_full=0 and o_idle=1; source strobes in that cycle SHALL be discarded.
REQ-031 Reset asserted mid-operation SHALL discard all queued results without emitting a writeback.
REQ-032 Stored data contents need not be reset; only valid state and counters are reset.

Verification
REQ-033 Single adder result dest=5, data=0xFFFFFFFF3F800000, flags=NX, i_wb_ready=1 -> o_wb_valid exactly one cycle later with the same payload; o_fflags=00001 afterwards; o_idle returns to 1.
REQ-034 All three sources valid on the same cycle, i_wb_ready=1 -> writebacks in order src0, src1, src2 on three consecutive cycles; the next simultaneous burst also starts at src0, since rr_ptr has wrapped to 0.
REQ-035 i_wb_ready=0, three pushes to src1 -> first two stored, o_src_full[1]=1, third dropped, o_overflow=1; on release, exactly two writebacks occur in push order.
REQ-036 Queue full, i_wb_ready=1, push on the same cycle as the pop -> no overflow, count stays 2, all three entries written back in order.
REQ-037 Handshake with flags=NV on the same cycle as i_fflags_clear=1, prior o_fflags=00001 -> o_fflags=10000.
REQ-038 i_rst asserted with two entries queued -> next cycle o_wb_valid=0, o_idle=1, o_fflags=0, o_overflow=0.
